// File: rtl/uart_tx_arb_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arb_if
//   Bundle of the client-side and transmitter-side byte handshakes of
//   uart_tx_arb.
//
//   cli_req   [N_REQ]   per-client byte valid, held with cli_data until the
//                       matching cli_ready pulse
//   cli_data  [8*N_REQ] client i byte on bits [8i+7:8i]
//   cli_ready [N_REQ]   one-cycle pulse: byte taken from client i
//   grant     [N_REQ]   one-hot current owner, zero when idle
//   tx_req              byte valid towards uart_tx
//   tx_data   [8]       byte towards uart_tx, stable while tx_req=1
//   tx_ready            uart_tx accepts tx_data when tx_req=1
//
//   master : the clients plus uart_tx (drive requests, data and tx_ready)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface uart_tx_arb_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   cli_req;
  logic [8*N_REQ-1:0] cli_data;
  logic [N_REQ-1:0]   cli_ready;
  logic [N_REQ-1:0]   grant;
  logic               tx_req;
  logic [7:0]         tx_data;
  logic               tx_ready;

  modport master (
    output cli_req,
    output cli_data,
    output tx_ready,
    input  cli_ready,
    input  grant,
    input  tx_req,
    input  tx_data
  );

  modport slave (
    input  cli_req,
    input  cli_data,
    input  tx_ready,
    output cli_ready,
    output grant,
    output tx_req,
    output tx_data
  );
endinterface

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//   Message-level round-robin arbiter sharing one uart_tx between N_REQ byte
//   producers. The winner keeps the transmitter until its end-of-message byte
//   (EOM_CHAR) has been accepted, so messages never interleave on the wire.
//
// Ports
//   clk     : single clock
//   reset_  : asynchronous, active-low reset
//   bus     : uart_tx_arb_if.slave (client req/data/ready, grant,
//             tx_req/tx_data/tx_ready)
//
// Parameters
//   N_REQ    : number of requesters (2..8)
//   EOM_CHAR : byte that ends a message and releases the lock
//   TIMEOUT  : idle-lock timeout in cycles (only with the macro below)
//
// Optional feature
//   Define UART_TX_ARB_TIMEOUT_EN to release a lock whose owner has left its
//   cli_req low for TIMEOUT consecutive LOCKED cycles. Without it the lock is
//   held until EOM_CHAR no matter how long the owner is idle.
//
// All outputs are registered; there is no combinational input-to-output path.
// ---------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int         N_REQ    = 4,
  parameter logic [7:0] EOM_CHAR = 8'h0A,
  parameter int         TIMEOUT  = 65535
) (
  input logic         clk,
  input logic         reset_,
  uart_tx_arb_if.slave bus
);

  localparam int OW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("uart_tx_arb: N_REQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_arb: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    SEND   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] cli_ready_q, cli_ready_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_owner_q, last_owner_d;
  logic             tx_req_q, tx_req_d;
  logic [7:0]       tx_data_q, tx_data_d;

  // Request and byte of the current owner.
  logic       owner_req;
  logic [7:0] owner_data;
  assign owner_req  = bus.cli_req[owner_q];
  assign owner_data = bus.cli_data[{owner_q, 3'b000} +: 8];

  logic tx_accept;
  assign tx_accept = tx_req_q && bus.tx_ready;

  logic timeout_hit;

  // -------------------------------------------------------------------------
  // Round-robin pick. Indices above last_owner have priority over those at or
  // below it; within each group the lowest index wins. Scanning downwards
  // lets the last hit (the lowest index) overwrite earlier ones.
  // -------------------------------------------------------------------------
  logic          hi_found, lo_found;
  logic [OW-1:0] hi_idx, lo_idx;
  logic          win_found;
  logic [OW-1:0] win_idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.cli_req[i]) begin
        if (OW'(i) > last_owner_q) begin
          hi_found = 1'b1;
          hi_idx   = OW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = OW'(i);
        end
      end
    end
    win_found = hi_found || lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] idle_cnt_q, idle_cnt_d;

  // Counts owner-idle cycles in LOCKED only; SEND holds it so transmitter
  // backpressure can never cause a release. Entering LOCKED from IDLE and
  // every accepted byte clear it.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      IDLE:    idle_cnt_d = '0;
      LOCKED:  idle_cnt_d = owner_req ? '0 : idle_cnt_q + 1'b1;
      default: idle_cnt_d = idle_cnt_q;
    endcase
  end

  // Fires on the cycle whose increment would make the count reach TIMEOUT.
  assign timeout_hit = (state_q == LOCKED) && !owner_req &&
                       (idle_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State register (and the registered outputs that travel with it).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      cli_ready_q  <= '0;
      owner_q      <= '0;
      // Search starts at last_owner+1, so requester 0 wins first.
      last_owner_q <= OW'(N_REQ - 1);
      tx_req_q     <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cli_ready_q  <= cli_ready_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tx_req_q     <= tx_req_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win_found) state_d = LOCKED;
      end
      LOCKED: begin
        if (owner_req)        state_d = SEND;
        else if (timeout_hit) state_d = IDLE;
      end
      SEND: begin
        if (tx_accept) state_d = (tx_data_q == EOM_CHAR) ? IDLE : LOCKED;
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath logic (next values of the registered outputs).
  // -------------------------------------------------------------------------
  always_comb begin
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tx_req_d     = tx_req_q;
    tx_data_d    = tx_data_q;
    cli_ready_d  = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          owner_d = win_idx;
        end
      end
      LOCKED: begin
        if (owner_req) begin
          tx_data_d   = owner_data;
          tx_req_d    = 1'b1;
          // grant_q is already the one-hot of the owner.
          cli_ready_d = grant_q;
        end else if (timeout_hit) begin
          last_owner_d = owner_q;
          grant_d      = '0;
        end
      end
      SEND: begin
        if (tx_accept) begin
          tx_req_d = 1'b0;
          if (tx_data_q == EOM_CHAR) begin
            last_owner_d = owner_q;
            grant_d      = '0;
          end
        end
      end
      default: begin
        grant_d  = '0;
        tx_req_d = 1'b0;
      end
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.cli_ready = cli_ready_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.tx_data   = tx_data_q;

endmodule
